// File: rtl/pic16_pkg.sv
// Shared definitions for the PIC16-class GPIO bank: register-select codes
// and the tristate reset pattern.
package pic16_pkg;

    typedef enum logic [2:0] {
        GPIO_PORT = 3'd0,
        GPIO_TRIS = 3'd1,
        GPIO_LAT  = 3'd2,
        GPIO_IOCP = 3'd3,
        GPIO_IOCN = 3'd4,
        GPIO_IOCF = 3'd5,
        GPIO_RSV6 = 3'd6,
        GPIO_RSV7 = 3'd7
    } gpio_reg_e;

    // All pins come out of reset as inputs.
    localparam logic [7:0] GPIO_TRIS_RST = 8'hFF;

endpackage

// File: rtl/pic16_gpio_bank_if.sv
// Special-register access path between the core and the GPIO bank.
interface pic16_gpio_bank_if #(
    parameter int AW = 4,
    parameter int W  = 8
);
    logic [AW-1:0] ADDR;
    logic          WE;
    logic [W-1:0]  WDATA;
    logic [W-1:0]  RDATA;

    modport master (output ADDR, output WE, output WDATA, input RDATA);
    modport slave  (input ADDR, input WE, input WDATA, output RDATA);
endinterface

// File: rtl/pic16_gpio_port.sv
// One GPIO port: output latch, tristate control, input synchroniser and
// interrupt-on-change with separate rising/falling enables.
module pic16_gpio_port
    import pic16_pkg::*;
#(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         we,
    input  logic         armed,
    input  gpio_reg_e    sel,
    input  logic [W-1:0] wdata,
    input  logic [W-1:0] pin_in,
    output logic [W-1:0] lat,
    output logic [W-1:0] tris,
    output logic [W-1:0] iocf,
    output logic [W-1:0] rdata
);

    localparam logic [7:0] TRIS_RST = GPIO_TRIS_RST;

    logic [W-1:0] iocp, iocn, prev, s, set_v;
    logic [W-1:0] sync_q [SYNC_STAGES];

    assign s     = sync_q[SYNC_STAGES-1];
    assign set_v = armed ? ((s & ~prev & iocp) | (~s & prev & iocn)) : '0;

    // NOTE: the synchroniser array is tiny and must come up clean, so it is
    // reset like any other register rather than left as uninitialised storage.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lat  <= '0;
            tris <= TRIS_RST[W-1:0];
            iocp <= '0;
            iocn <= '0;
            iocf <= '0;
            prev <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage shift on the
            // same edge without depending on statement order.
            sync_q[0] <= pin_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev <= s;
            if (we) begin
                case (sel)
                    GPIO_PORT, GPIO_LAT: lat  <= wdata;
                    GPIO_TRIS:           tris <= wdata;
                    GPIO_IOCP:           iocp <= wdata;
                    GPIO_IOCN:           iocn <= wdata;
                    default: ;
                endcase
            end
            // A hardware set in the same cycle as a software clear wins.
            iocf <= ((we && sel == GPIO_IOCF) ? (iocf & wdata) : iocf) | set_v;
        end
    end

    // NOTE: rdata gets a default first so no path through the case infers a latch.
    always_comb begin
        rdata = '0;
        case (sel)
            GPIO_PORT: rdata = s;
            GPIO_TRIS: rdata = tris;
            GPIO_LAT:  rdata = lat;
            GPIO_IOCP: rdata = iocp;
            GPIO_IOCN: rdata = iocn;
            GPIO_IOCF: rdata = iocf;
            default:   rdata = '0;
        endcase
    end

endmodule

// File: rtl/pic16_gpio_bank.sv
// Parametrised GPIO bank: address decode, read mux, pin drivers, IRQ OR and
// the post-reset arming counter around NPORT port instances.
module pic16_gpio_bank
    import pic16_pkg::*;
#(
    parameter int NPORT       = 2,
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AW          = $clog2(NPORT) + 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    pic16_gpio_bank_if.slave     bus,
    inout  wire  [NPORT*W-1:0]   PIO,
    output logic                 IRQ
);

    localparam int ARM_CYCLES = SYNC_STAGES + 1;
    localparam int CW         = $clog2(ARM_CYCLES + 1);

    logic [AW-1:0]             addr, pidx;
    gpio_reg_e                 sel;
    logic [CW-1:0]             arm_cnt;
    logic                      armed;
    logic [NPORT-1:0]          we_v;
    logic [NPORT-1:0][W-1:0]   lat_v, tris_v, iocf_v, rd_v;
    logic [W-1:0]              rdata_mux;

    assign addr  = bus.ADDR;
    assign pidx  = addr >> 3;
    assign sel   = gpio_reg_e'(addr[2:0]);
    assign armed = (arm_cnt == CW'(ARM_CYCLES));

    // Detection stays off until the synchroniser and PREV hold real pin data.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)         arm_cnt <= '0;
        else if (!armed) arm_cnt <= arm_cnt + 1'b1;
    end

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        assign we_v[p] = bus.WE && (pidx == AW'(p));

        pic16_gpio_port #(.W(W), .SYNC_STAGES(SYNC_STAGES)) u_port (
            .CLK    (CLK),
            .RST    (RST),
            .we     (we_v[p]),
            .armed  (armed),
            .sel    (sel),
            .wdata  (bus.WDATA),
            .pin_in (PIO[p*W +: W]),
            .lat    (lat_v[p]),
            .tris   (tris_v[p]),
            .iocf   (iocf_v[p]),
            .rdata  (rd_v[p])
        );

        for (genvar b = 0; b < W; b++) begin : g_pin
            assign PIO[p*W + b] = tris_v[p][b] ? 1'bz : lat_v[p][b];
        end
    end

    // Port indices at or beyond NPORT match no instance and read 0.
    always_comb begin
        rdata_mux = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (pidx == AW'(p)) rdata_mux = rd_v[p];
        end
    end

    assign bus.RDATA = rdata_mux;
    assign IRQ       = |iocf_v;

endmodule
